// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM state encoding and
// the round-robin wrap helper.
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin first-one finder: scans req_i from ptr_i upward,
// wrapping at NUM_REQ-1, and reports the first set bit.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    output logic               valid_o,
    output logic [IW-1:0]      idx_o
);

    int unsigned j;

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        j       = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            j = 32'(ptr_i) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!valid_o && req_i[j]) begin
                valid_o = 1'b1;
                idx_o   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// granting bursts of up to MAX_BURST words with zero-latency write strobes.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           gnt,
    input  logic                         fifo_full,
    output logic                         fifo_wr_en,
    output logic [DATA_W-1:0]            fifo_wr_data,
    output logic [$clog2(NUM_REQ)-1:0]   active_id,
    output logic                         busy
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;

    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] owner_next;
    logic          accept;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr_pick (
        .req_i   (req),
        .ptr_i   (rr_ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    assign owner_next = IW'(rr_wrap_inc(32'(owner_q), NUM_REQ));
    assign accept     = (state_q == ST_BURST) && req[owner_q] && !fifo_full;
    assign active_id  = owner_q;
    assign busy       = (state_q == ST_BURST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        burst_cnt_d  = burst_cnt_q;
        gnt          = '0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    owner_d     = pick_idx;
                    burst_cnt_d = '0;
                    state_d     = ST_BURST;
                end
            end
            ST_BURST: begin
                // A dropped request ends the burst even while the FIFO is full.
                if (!req[owner_q]) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = owner_next;
                end else if (accept) begin
                    gnt[owner_q] = 1'b1;
                    fifo_wr_en   = 1'b1;
                    fifo_wr_data = req_data[owner_q*DATA_W +: DATA_W];
                    burst_cnt_d  = burst_cnt_q + 1'b1;
                    if (req_last[owner_q] || burst_cnt_q == CW'(MAX_BURST - 1)) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = owner_next;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed scoreboard bench for fifo_wr_arbiter: requester models feed words,
// a monitor compares every FIFO write against the expected queue.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   gnt;
    logic            fifo_full;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_wr_data;
    logic [1:0]      active_id;
    logic            busy;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ   (NR),
        .DATA_W    (DW),
        .MAX_BURST (MB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_data     (req_data),
        .req_last     (req_last),
        .gnt          (gnt),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .active_id    (active_id),
        .busy         (busy)
    );

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    logic [7:0]  wdat [NR][32];
    logic        wlst [NR][32];
    int unsigned wptr [NR];
    int unsigned wcnt [NR];
    logic [NR-1:0] g;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load(input int id, input logic [7:0] d, input logic l);
        wdat[id][wcnt[id]] = d;
        wlst[id][wcnt[id]] = l;
        wcnt[id]++;
    endtask

    task automatic push(input logic [1:0] id, input logic [7:0] d);
        exp_t e;
        e.id   = id;
        e.data = d;
        sb.push_back(e);
    endtask

    function automatic bit pending();
        for (int i = 0; i < NR; i++) begin
            if (wptr[i] < wcnt[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req[i]            = (wptr[i] < wcnt[i]);
            req_data[i*DW +: DW] = req[i] ? wdat[i][wptr[i]] : 8'h00;
            req_last[i]       = req[i] ? wlst[i][wptr[i]] : 1'b0;
        end
    endtask

    task automatic wait_writes(input int id, input int n, input int budget);
        int seen = 0;
        int c    = 0;
        while (seen < n && c < budget) begin
            @(negedge clk);
            c++;
            if (fifo_wr_en && gnt[id]) seen++;
        end
        if (seen < n) begin
            checks++;
            failures++;
            $display("FAIL wait_writes_id%0d: saw %0d required %0d", id, seen, n);
        end
    endtask

    task automatic drain(input int budget);
        int c = 0;
        while ((sb.size() != 0 || pending()) && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (c >= budget) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: sb=%0d pending=%0d required 0", sb.size(), pending());
        end
        repeat (3) @(negedge clk);
        check("drain_busy", busy, 0);
    endtask

    // Requester models: advance on the grant seen just before the clock edge.
    initial begin
        for (int i = 0; i < NR; i++) begin
            wptr[i] = 0;
            wcnt[i] = 0;
        end
        req      = '0;
        req_data = '0;
        req_last = '0;
        g        = '0;
        forever begin
            @(negedge clk);
            g = gnt;
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (g[i] && wptr[i] < wcnt[i]) wptr[i]++;
            end
            drive();
        end
    end

    // Monitor: every FIFO write must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (fifo_wr_en) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got gnt=%0h data=%0h expected no write", gnt, fifo_wr_data);
                end else begin
                    e = sb.pop_front();
                    check("wr_data", fifo_wr_data, e.data);
                    check("wr_gnt", gnt, 32'(4'b0001 << e.id));
                end
            end else begin
                check("idle_bus", {gnt, fifo_wr_data}, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        fifo_full = 1'b0;

        // 1: reset with all requesting, then grant id 0 after one bubble
        for (int i = 0; i < NR; i++) begin
            load(i, 8'(8'hA0 + i), 1'b1);
            push(2'(i), 8'(8'hA0 + i));
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_wr_data", fifo_wr_data, 0);
        check("rst_active_id", active_id, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("t1_bubble_busy", busy, 0);
        check("t1_bubble_wr_en", fifo_wr_en, 0);
        @(negedge clk);
        check("t1_first_busy", busy, 1);
        check("t1_first_gnt", gnt, 4'b0001);
        check("t1_first_id", active_id, 0);
        drain(100);

        // 3: all requesting without last, bursts capped at MAX_BURST
        for (int k = 0; k < 8; k++) load(0, 8'(k), 1'b0);
        for (int i = 1; i < NR; i++) begin
            for (int k = 0; k < 4; k++) load(i, 8'(16 * i + k), 1'b0);
        end
        for (int i = 0; i < NR; i++) begin
            for (int k = 0; k < 4; k++) push(2'(i), 8'(16 * i + k));
        end
        for (int k = 4; k < 8; k++) push(2'd0, 8'(k));
        drain(300);
        check("t3_active_id", active_id, 0);

        // 2: single requester packet with last on third word
        load(2, 8'h34, 1'b0);
        load(2, 8'hA8, 1'b0);
        load(2, 8'h0F, 1'b1);
        push(2'd2, 8'h34);
        push(2'd2, 8'hA8);
        push(2'd2, 8'h0F);
        drain(100);
        check("t2_active_id", active_id, 2);

        // 4: backpressure mid-burst; count must hold so id 2 gets its turn after 4 words
        for (int k = 0; k < 6; k++) load(1, 8'(8'h50 + k), k == 5);
        load(2, 8'h60, 1'b1);
        for (int k = 0; k < 4; k++) push(2'd1, 8'(8'h50 + k));
        push(2'd2, 8'h60);
        push(2'd1, 8'h54);
        push(2'd1, 8'h55);
        wait_writes(1, 2, 50);
        @(posedge clk);
        #1 fifo_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t4_full_gnt", gnt, 0);
            check("t4_full_wr_en", fifo_wr_en, 0);
            check("t4_full_busy", busy, 1);
            check("t4_full_owner", active_id, 1);
        end
        @(posedge clk);
        #1 fifo_full = 1'b0;
        drain(100);

        // 5: owner drops request after two words, waiting id 1 served next
        load(3, 8'h70, 1'b0);
        load(3, 8'h71, 1'b0);
        load(1, 8'h7A, 1'b1);
        push(2'd3, 8'h70);
        push(2'd3, 8'h71);
        push(2'd1, 8'h7A);
        wait_writes(3, 2, 50);
        @(negedge clk);
        check("t5_drop_busy", busy, 1);
        check("t5_drop_wr_en", fifo_wr_en, 0);
        @(negedge clk);
        check("t5_idle_busy", busy, 0);
        @(negedge clk);
        check("t5_next_gnt", gnt, 4'b0010);
        check("t5_next_id", active_id, 1);
        drain(100);

        // 6: async reset mid-burst, then arbitration restarts from id 0
        for (int k = 0; k < 4; k++) load(2, 8'(8'h80 + k), 1'b0);
        push(2'd2, 8'h80);
        push(2'd2, 8'h81);
        wait_writes(2, 2, 50);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_gnt", gnt, 0);
        check("t6_rst_wr_en", fifo_wr_en, 0);
        check("t6_rst_wr_data", fifo_wr_data, 0);
        check("t6_rst_active_id", active_id, 0);
        check("t6_rst_busy", busy, 0);
        wcnt[2] = wptr[2];
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        load(3, 8'h90, 1'b1);
        load(0, 8'h91, 1'b1);
        push(2'd0, 8'h91);
        push(2'd3, 8'h90);
        drain(100);

        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
